// File: rtl/btn_op_conditioner.sv
// Board-side front end: synchronises switches and pushbuttons, debounces the buttons and
// turns button presses into a held one-hot operation select with a one-cycle op_valid pulse.
module btn_op_conditioner #(
  parameter int BITS      = 16,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic            CLK100MHZ,
  input  logic            CPU_RESETN,
  input  logic [4:0]      btn_in,
  input  logic [BITS-1:0] sw_in,
  output logic [BITS-1:0] sw,
  output logic            BTNC,
  output logic            BTNU,
  output logic            BTND,
  output logic            BTNL,
  output logic            BTNR,
  output logic            op_valid
);

  localparam int              CW      = $clog2(DB_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DB_CYCLES - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [BITS-1:0] sw_s1;
  logic [4:0]      btn_s1, btn_s2;
  logic [4:0]      btn_stable, btn_stable_d;
  logic [CW-1:0]   db_cnt [5];
  logic [4:0]      press, sel;
  logic [4:0]      op_q;
  state_t          state;

  // Two-flop synchronisers; sw is the second stage itself.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      sw_s1  <= '0;
      sw     <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      sw_s1  <= sw_in;
      sw     <= sw_s1;
      btn_s1 <= btn_in;
      btn_s2 <= btn_s1;
    end
  end

  // Per-button debounce: accept a new level only after DB_CYCLES consecutive mismatches.
  // NOTE: the counter array is tiny and must restart on reset, so it is reset like plain flops.
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      btn_stable   <= '0;
      btn_stable_d <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      btn_stable_d <= btn_stable;
      for (int i = 0; i < 5; i++) begin
        if (btn_s2[i] != btn_stable[i]) begin
          if (db_cnt[i] == CNT_MAX) begin
            btn_stable[i] <= btn_s2[i];
            db_cnt[i]     <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + CW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign press = btn_stable & ~btn_stable_d;

  // Fixed priority C > U > D > L > R among presses seen in the same cycle.
  // NOTE: sel gets a default before the if-chain so no latch is inferred.
  always_comb begin
    sel = '0;
    if      (press[0]) sel = 5'b00001;
    else if (press[1]) sel = 5'b00010;
    else if (press[2]) sel = 5'b00100;
    else if (press[3]) sel = 5'b01000;
    else if (press[4]) sel = 5'b10000;
  end

  // Presses landing in the cycle right after a latch are dropped so op_valid never doubles up.
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      state    <= IDLE;
      op_q     <= '0;
      op_valid <= 1'b0;
    end else begin
      op_valid <= 1'b0;
      if (sel != '0 && !op_valid) begin
        case (state)
          IDLE: begin
            state    <= ACTIVE;
            op_q     <= sel;
            op_valid <= 1'b1;
          end
          ACTIVE: begin
            if (sel == op_q) begin
              state <= IDLE;
              op_q  <= '0;
            end else begin
              op_q     <= sel;
              op_valid <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            op_q  <= '0;
          end
        endcase
      end
    end
  end

  assign BTNC = op_q[0];
  assign BTNU = op_q[1];
  assign BTND = op_q[2];
  assign BTNL = op_q[3];
  assign BTNR = op_q[4];

endmodule
